img_color_proc: RTL and testbench

//  Frame processing stage downstream of the camera frame buffer. On a start

---
 rtl/img_color_proc_pkg.sv | 42 ++++
 rtl/img_pxl_op.sv | 51 +++++
 rtl/img_color_proc.sv | 166 ++++++++++++++++
 tb/tb_img_color_proc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_color_proc_pkg.sv
// Shared definitions for the frame colour-processing stage.
// Frame geometry, pixel format, op codes and FSM encodings.
// RGB444 field helpers used by the pixel operator and its users.
package img_color_proc_pkg;

  localparam int c_img_cols    = 120;
  localparam int c_img_rows    = 90;
  localparam int c_img_pxls    = c_img_cols * c_img_rows;
  localparam int c_nb_img_pxls = 14;
  localparam int c_nb_buf      = 12;
  localparam int c_red_thr     = 4;

  // Pixel operation selected by proc_sel
  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_GRAY = 2'd1,
    OP_RED  = 2'd2,
    OP_INV  = 2'd3
  } op_t;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // RGB444 field slices, {R[11:8], G[7:4], B[3:0]}
  function automatic logic [3:0] px_r(input logic [c_nb_buf-1:0] p);
    return p[11:8];
  endfunction

  function automatic logic [3:0] px_g(input logic [c_nb_buf-1:0] p);
    return p[7:4];
  endfunction

  function automatic logic [3:0] px_b(input logic [c_nb_buf-1:0] p);
    return p[3:0];
  endfunction

endpackage

// File: rtl/img_pxl_op.sv
// Combinational RGB444 pixel operator: pass, gray, red-mask, invert, plus red flag.
// Latency: 0 clks (pure combinational).
// Backpressure: none; result follows the input every cycle.
module img_pxl_op
  import img_color_proc_pkg::*;
(
  input  logic [c_nb_buf-1:0] pxl,
  input  op_t                 op,
  input  logic [3:0]          thr,
  output logic [c_nb_buf-1:0] out_pxl,
  output logic                is_red
);

  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic [5:0] gray_sum;
  logic [3:0] y;
  logic [4:0] g_lim;
  logic [4:0] b_lim;

  assign r = px_r(pxl);
  assign g = px_g(pxl);
  assign b = px_b(pxl);

  // Luma approximation (r + 2g + b) / 4; the 6-bit sum never exceeds 60 so y <= 15
  always_comb begin
    gray_sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    y        = 4'(gray_sum >> 2);
  end

  // Red classifier: red channel must beat both others by thr, 5-bit so g+thr cannot wrap
  always_comb begin
    g_lim  = {1'b0, g} + {1'b0, thr};
    b_lim  = {1'b0, b} + {1'b0, thr};
    is_red = ({1'b0, r} >= g_lim) && ({1'b0, r} >= b_lim);
  end

  // Output mux over the selected operation
  always_comb begin
    out_pxl = pxl;
    case (op)
      OP_PASS: out_pxl = pxl;
      OP_GRAY: out_pxl = {y, y, y};
      OP_RED:  out_pxl = is_red ? 12'hFFF : 12'h000;
      OP_INV:  out_pxl = ~pxl;
      default: out_pxl = pxl;
    endcase
  end

endmodule

// File: rtl/img_color_proc.sv
// Streams a captured RGB444 frame through a colour op into the processed buffer, counting red pixels.
// Latency: 2 clks from read address to write; done 1 clk after the last write.
// Backpressure: none; one pixel per clk, start ignored while busy or in DONE.
module img_color_proc
  import img_color_proc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               proc_sel,
  output logic [c_nb_img_pxls-1:0] orig_addr,
  input  logic [c_nb_buf-1:0]      orig_pxl,
  output logic [c_nb_img_pxls-1:0] proc_addr,
  output logic [c_nb_buf-1:0]      proc_pxl,
  output logic                     proc_we,
  output logic                     busy,
  output logic                     done,
  output logic [c_nb_img_pxls-1:0] red_cnt
);

  localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);
  localparam logic [c_nb_img_pxls-1:0] c_cnt_max   = '1;

  state_t                   state_q;
  state_t                   state_d;
  logic                     drain_q;
  logic [c_nb_img_pxls-1:0] addr_q;
  op_t                      sel_q;

  logic                     s1_vld_q;
  logic [c_nb_img_pxls-1:0] s1_addr_q;
  logic                     s2_vld_q;
  logic [c_nb_img_pxls-1:0] s2_addr_q;
  logic [c_nb_buf-1:0]      s2_pxl_q;
  logic                     s2_red_q;

  logic [c_nb_img_pxls-1:0] red_acc_q;
  logic [c_nb_img_pxls-1:0] red_acc_d;
  logic [c_nb_img_pxls-1:0] red_cnt_q;

  logic                     start_acc;
  logic                     last_addr;
  logic                     frame_end;
  logic [c_nb_buf-1:0]      op_pxl;
  logic                     op_red;

  assign start_acc = start && (state_q == ST_IDLE);
  assign last_addr = (addr_q == c_last_addr);
  // Final DRAIN clk: the last pixel is being written, DONE follows
  assign frame_end = (state_q == ST_DRAIN) && drain_q;

  // FSM state register plus the two-clk drain timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)     state_d = ST_RUN;
      ST_RUN:   if (last_addr) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q)   state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Read address counter; returns to 0 after the last pixel so it idles at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (state_q == ST_RUN) begin
      addr_q <= last_addr ? '0 : addr_q + 1'b1;
    end else begin
      addr_q <= '0;
    end
  end

  // Operation is latched on the accepted start so proc_sel may change mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= OP_PASS;
    end else if (start_acc) begin
      sel_q <= op_t'(proc_sel);
    end
  end

  assign orig_addr = addr_q;

  img_pxl_op u_pxl_op (
    .pxl     (orig_pxl),
    .op      (sel_q),
    .thr     (4'(c_red_thr)),
    .out_pxl (op_pxl),
    .is_red  (op_red)
  );

  // Stage 1 tracks the address whose data arrives from the buffer this clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
    end else begin
      s1_vld_q  <= (state_q == ST_RUN);
      s1_addr_q <= addr_q;
    end
  end

  // Stage 2 registers the op result and red flag and drives the write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_pxl_q  <= '0;
      s2_red_q  <= 1'b0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_addr_q <= s1_vld_q ? s1_addr_q : '0;
      s2_pxl_q  <= s1_vld_q ? op_pxl : '0;
      s2_red_q  <= s1_vld_q && op_red;
    end
  end

  assign proc_we   = s2_vld_q;
  assign proc_addr = s2_addr_q;
  assign proc_pxl  = s2_pxl_q;

  // Red accumulator: cleared on start, counts flagged writes, saturates at all-ones
  always_comb begin
    red_acc_d = red_acc_q;
    if (start_acc) begin
      red_acc_d = '0;
    end else if (s2_vld_q && s2_red_q && (red_acc_q != c_cnt_max)) begin
      red_acc_d = red_acc_q + 1'b1;
    end
  end

  // Published count loads together with the last write so it is valid while done is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_acc_q <= '0;
      red_cnt_q <= '0;
    end else begin
      red_acc_q <= red_acc_d;
      if (frame_end) begin
        red_cnt_q <= red_acc_d;
      end
    end
  end

  assign red_cnt = red_cnt_q;

endmodule

// File: tb/tb_img_color_proc.sv
module tb_img_color_proc;

  localparam int NPX = 10800;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  proc_sel;
  logic [13:0] orig_addr;
  logic [11:0] orig_pxl = '0;
  logic [13:0] proc_addr;
  logic [11:0] proc_pxl;
  logic        proc_we;
  logic        busy;
  logic        done;
  logic [13:0] red_cnt;

  logic [11:0] src_mem [0:NPX-1];
  logic [11:0] dst_mem [0:NPX-1];

  int n_tests = 0;
  int n_fail  = 0;

  // frame bookkeeping: frame_id written only by the stimulus, counters only by the monitor
  int         frame_id = 0;
  int         seen_id  = 0;
  logic [1:0] cur_sel  = 2'd0;
  int cyc = 0;
  int wr_cnt = 0, pix_err = 0, addr_err = 0, done_cnt = 0;
  int first_we = 0, done_cyc = 0, busy_rise = 0;
  logic prev_busy = 1'b0;

  always #10 clk = ~clk;

  img_color_proc dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .proc_sel  (proc_sel),
    .orig_addr (orig_addr),
    .orig_pxl  (orig_pxl),
    .proc_addr (proc_addr),
    .proc_pxl  (proc_pxl),
    .proc_we   (proc_we),
    .busy      (busy),
    .done      (done),
    .red_cnt   (red_cnt)
  );

  // source buffer with 1-clk read latency
  always @(posedge clk) begin
    if (int'(orig_addr) < NPX) orig_pxl <= src_mem[orig_addr];
    else                       orig_pxl <= 12'h000;
  end

  function automatic bit red_m(input logic [11:0] p);
    int r, g, b;
    r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
    return (r >= g + 4) && (r >= b + 4);
  endfunction

  function automatic logic [11:0] exp_op(input logic [11:0] p, input logic [1:0] s);
    int r, g, b;
    logic [3:0] y;
    r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
    y = 4'((r + 2 * g + b) / 4);
    case (s)
      2'd0:    return p;
      2'd1:    return {y, y, y};
      2'd2:    return red_m(p) ? 12'hFFF : 12'h000;
      default: return ~p;
    endcase
  endfunction

  function automatic int red_total();
    int n = 0;
    for (int i = 0; i < NPX; i++) if (red_m(src_mem[i])) n++;
    return n;
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // write-port monitor
  always @(negedge clk) begin
    cyc++;
    if (frame_id != seen_id) begin
      seen_id = frame_id;
      wr_cnt = 0; pix_err = 0; addr_err = 0; done_cnt = 0;
      first_we = 0; done_cyc = 0; busy_rise = 0;
    end
    if (busy && !prev_busy) busy_rise = cyc;
    prev_busy = busy;
    if (proc_we) begin
      if (wr_cnt == 0) first_we = cyc;
      if (int'(proc_addr) != wr_cnt || int'(proc_addr) >= NPX) addr_err++;
      else begin
        if (proc_pxl != exp_op(src_mem[proc_addr], cur_sel)) pix_err++;
        dst_mem[proc_addr] = proc_pxl;
      end
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic kick(input logic [1:0] sel);
    frame_id++;
    cur_sel  = sel;
    proc_sel = sel;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_addr(input int a, input string tag);
    bit hit = 0;
    for (int i = 0; i < NPX + 10 && !hit; i++) begin
      @(negedge clk); #1;
      if (int'(orig_addr) == a) hit = 1;
    end
    check(tag, int'(hit), 1);
  endtask

  task automatic finish_frame(input string tag, input int exp_red);
    bit seen = 0;
    for (int i = 0; i < NPX + 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_red_cnt"}, int'(red_cnt), exp_red);
    @(negedge clk); #1;
    check({tag, "_done_width"}, int'(done), 0);
    check({tag, "_busy_fall"}, int'(busy), 0);
    check({tag, "_writes"}, wr_cnt, NPX);
    check({tag, "_pix_err"}, pix_err, 0);
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_lat"}, first_we - busy_rise, 2);
    check({tag, "_we_span"}, done_cyc - first_we, NPX);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; proc_sel = 2'd0;
    for (int i = 0; i < NPX; i++) begin
      src_mem[i] = i[11:0];
      dst_mem[i] = 12'h000;
    end
    tick(); tick();
    check("rst_orig_addr", int'(orig_addr), 0);
    check("rst_we_busy_done", int'({proc_we, busy, done}), 0);
    check("rst_proc_addr_pxl", int'({proc_addr, proc_pxl}), 0);
    check("rst_red_cnt", int'(red_cnt), 0);
    rst = 1'b0;
    tick();

    // 1: pass-through over the ramp frame
    kick(2'd0);
    finish_frame("pass", red_total());
    check("pass_px5000", int'(dst_mem[5000]), 5000 % 4096);

    // 2: gray
    src_mem[0] = 12'hF84;
    src_mem[1] = 12'hFFF;
    kick(2'd1);
    finish_frame("gray", red_total());
    check("gray_F84", int'(dst_mem[0]), 12'h888);
    check("gray_FFF", int'(dst_mem[1]), 12'hFFF);

    // 3: red mask over a frame with 37 red pixels
    for (int i = 0; i < NPX; i++) src_mem[i] = 12'h000;
    for (int i = 0; i < 37; i++) src_mem[i * 250] = 12'hA60;
    src_mem[1] = 12'h970;
    kick(2'd2);
    finish_frame("red", 37);
    check("red_A60", int'(dst_mem[0]), 12'hFFF);
    check("red_970", int'(dst_mem[1]), 12'h000);

    // 4 + 6: invert, with a spurious start and a proc_sel change mid-frame
    for (int i = 0; i < NPX; i++) src_mem[i] = i[11:0];
    src_mem[2] = 12'h0F0;
    kick(2'd3);
    wait_addr(100, "inv_reach100");
    proc_sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame("inv", red_total());
    check("inv_0F0", int'(dst_mem[2]), 12'hF0F);

    // 6: back-to-back start on the clk after done
    kick(2'd0);
    #1;
    check("b2b_busy", int'(busy), 1);
    finish_frame("b2b", red_total());

    // 5: reset at pixel 500
    kick(2'd0);
    wait_addr(500, "rst_reach500");
    rst = 1'b1;
    #1;
    check("mid_rst_orig_addr", int'(orig_addr), 0);
    check("mid_rst_we_busy_done", int'({proc_we, busy, done}), 0);
    check("mid_rst_proc_addr_pxl", int'({proc_addr, proc_pxl}), 0);
    check("mid_rst_red_cnt", int'(red_cnt), 0);
    tick(); tick();
    check("mid_rst_no_done", done_cnt, 0);
    rst = 1'b0;
    tick();
    kick(2'd0);
    finish_frame("post_rst", red_total());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
